// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO block: register offsets, the APB FSM
// state type and the register-offset decode helper.
package apb_gpio_pkg;

   localparam int DEC_W = 3;

   localparam logic [DEC_W-1:0] OFS_IN      = 3'd0;
   localparam logic [DEC_W-1:0] OFS_OUT     = 3'd1;
   localparam logic [DEC_W-1:0] OFS_DIR     = 3'd2;
   localparam logic [DEC_W-1:0] OFS_RISE_EN = 3'd3;
   localparam logic [DEC_W-1:0] OFS_FALL_EN = 3'd4;
   localparam logic [DEC_W-1:0] OFS_STATUS  = 3'd5;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } apb_state_e;

   // Offsets past STATUS (0x18, 0x1C) are holes in the map.
   function automatic logic ofs_unmapped(input logic [DEC_W-1:0] ofs);
      return (ofs > OFS_STATUS);
   endfunction

endpackage

// File: rtl/apb_gpio_irq_sync.sv
// Two-flop synchroniser for asynchronous pad inputs, plus a history flop used
// to produce single-cycle rise/fall pulses on the synchronised value.
module gpio_sync_edge #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_pins,
   output logic [WIDTH-1:0] o_sync,
   output logic [WIDTH-1:0] o_rise,
   output logic [WIDTH-1:0] o_fall
);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_prev;

   // r_prev clears with the rest, so a pin already high at reset release
   // produces one rise pulse; the enables are 0 then, so nothing latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync1 <= i_pins;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign o_sync = r_sync2;
   assign o_rise = r_sync2 & ~r_prev;
   assign o_fall = ~r_sync2 & r_prev;

endmodule

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO peripheral: OUT/DIR/edge-enable registers, sticky W1C edge status
// and a registered level interrupt. Zero-wait-state APB slave.
module apb_gpio_irq
   import apb_gpio_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int BUS_WIDTH     = 4,
   parameter int GPIO_WIDTH    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] s_apb_paddr,
   input  logic                     s_apb_psel,
   input  logic                     s_apb_penable,
   output logic                     s_apb_pready,
   input  logic                     s_apb_pwrite,
   input  logic [8*BUS_WIDTH-1:0]   s_apb_pwdata,
   output logic [8*BUS_WIDTH-1:0]   s_apb_prdata,
   output logic                     s_apb_pslverror,
   input  logic [GPIO_WIDTH-1:0]    gpio_i,
   output logic [GPIO_WIDTH-1:0]    gpio_o,
   output logic [GPIO_WIDTH-1:0]    gpio_oe,
   output logic                     irq,
   output logic                     o_dbg_state
);

   localparam int DATA_W = 8 * BUS_WIDTH;

   apb_state_e r_state;
   apb_state_e w_state_next;

   logic [GPIO_WIDTH-1:0] r_out;
   logic [GPIO_WIDTH-1:0] r_dir;
   logic [GPIO_WIDTH-1:0] r_rise_en;
   logic [GPIO_WIDTH-1:0] r_fall_en;
   logic [GPIO_WIDTH-1:0] r_status;
   logic                  r_irq;
   logic [DATA_W-1:0]     r_prdata;
   logic                  r_pslverror;

   logic [GPIO_WIDTH-1:0] w_sync;
   logic [GPIO_WIDTH-1:0] w_rise;
   logic [GPIO_WIDTH-1:0] w_fall;
   logic [GPIO_WIDTH-1:0] w_wdata;
   logic [GPIO_WIDTH-1:0] w_clr;
   logic [DEC_W-1:0]      w_ofs;
   logic                  w_setup;
   logic                  w_commit;
   logic [DATA_W-1:0]     w_rd_data;
   logic                  w_rd_err;
   logic                  w_unused;

   gpio_sync_edge #(
      .WIDTH (GPIO_WIDTH)
   ) u_sync_edge (
      .clk    (clk),
      .rst    (rst),
      .i_pins (gpio_i),
      .o_sync (w_sync),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   // Handshake: setup is psel & ~penable seen in IDLE; the following cycle is
   // ACCESS with pready=1, and a write commits on the edge that ends it only
   // if psel & penable still hold. penable without a prior setup is ignored.
   assign w_ofs    = s_apb_paddr[4:2];
   assign w_wdata  = s_apb_pwdata[GPIO_WIDTH-1:0];
   assign w_setup  = (r_state == ST_IDLE) & s_apb_psel & ~s_apb_penable;
   assign w_commit = (r_state == ST_ACCESS) & s_apb_psel & s_apb_penable & s_apb_pwrite;
   assign w_clr    = (w_commit && (w_ofs == OFS_STATUS)) ? w_wdata : '0;

   always_comb begin
      w_state_next = r_state;
      if (r_state == ST_IDLE) begin
         if (s_apb_psel && !s_apb_penable) begin
            w_state_next = ST_ACCESS;
         end
      end else begin
         w_state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Read data is captured at setup, so IN reflects the pins as of that cycle.
   always_comb begin
      w_rd_data = '0;
      w_rd_err  = ofs_unmapped(w_ofs);
      case (w_ofs)
         OFS_IN:      w_rd_data[GPIO_WIDTH-1:0] = w_sync;
         OFS_OUT:     w_rd_data[GPIO_WIDTH-1:0] = r_out;
         OFS_DIR:     w_rd_data[GPIO_WIDTH-1:0] = r_dir;
         OFS_RISE_EN: w_rd_data[GPIO_WIDTH-1:0] = r_rise_en;
         OFS_FALL_EN: w_rd_data[GPIO_WIDTH-1:0] = r_fall_en;
         OFS_STATUS:  w_rd_data[GPIO_WIDTH-1:0] = r_status;
         default:     w_rd_data = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prdata    <= '0;
         r_pslverror <= 1'b0;
      end else if (w_setup) begin
         r_prdata    <= w_rd_data;
         r_pslverror <= w_rd_err;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out     <= '0;
         r_dir     <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
      end else if (w_commit) begin
         case (w_ofs)
            OFS_OUT:     r_out     <= w_wdata;
            OFS_DIR:     r_dir     <= w_wdata;
            OFS_RISE_EN: r_rise_en <= w_wdata;
            OFS_FALL_EN: r_fall_en <= w_wdata;
            default:     ;
         endcase
      end
   end

   // Set terms are ORed after the clear, so an edge landing with a W1C wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_status <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_status <= (r_status & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
         r_irq    <= |r_status;
      end
   end

   assign s_apb_pready    = (r_state == ST_ACCESS);
   assign s_apb_prdata    = r_prdata;
   assign s_apb_pslverror = r_pslverror;
   assign gpio_o          = r_out;
   assign gpio_oe         = r_dir;
   assign irq             = r_irq;
   assign o_dbg_state     = r_state;

   // Address bits outside [4:2] and data bits above GPIO_WIDTH are don't-care.
   assign w_unused = ^{s_apb_paddr, s_apb_pwdata};

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Self-checking bench for apb_gpio_irq: directed scenarios plus randomized bus
// and pin activity, checked against a pin-history reference model.
module tb_apb_gpio_irq;

   localparam int AW = 32;
   localparam int BW = 4;
   localparam int DW = 32;
   localparam int GW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] paddr = '0;
   logic          psel = 1'b0;
   logic          penable = 1'b0;
   logic          pwrite = 1'b0;
   logic [DW-1:0] pwdata = '0;
   logic          pready;
   logic [DW-1:0] prdata;
   logic          pslverror;
   logic [GW-1:0] gpio_i = '0;
   logic [GW-1:0] gpio_o;
   logic [GW-1:0] gpio_oe;
   logic          irq;
   logic          dbg_state;

   apb_gpio_irq #(
      .ADDRESS_WIDTH (AW),
      .BUS_WIDTH     (BW),
      .GPIO_WIDTH    (GW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .s_apb_paddr     (paddr),
      .s_apb_psel      (psel),
      .s_apb_penable   (penable),
      .s_apb_pready    (pready),
      .s_apb_pwrite    (pwrite),
      .s_apb_pwdata    (pwdata),
      .s_apb_prdata    (prdata),
      .s_apb_pslverror (pslverror),
      .gpio_i          (gpio_i),
      .gpio_o          (gpio_o),
      .gpio_oe         (gpio_oe),
      .irq             (irq),
      .o_dbg_state     (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Pin values seen at each clock edge, newest first. A pin change reaches IN
   // two edges later and the edge it forms is judged one edge after that.
   logic [GW-1:0] m_pins[$];
   logic [GW-1:0] m_out = '0, m_dir = '0, m_rise = '0, m_fall = '0, m_status = '0;
   logic          m_irq = 1'b0;
   logic [32:0]   exp_q[$];

   bit            wr_pend = 1'b0;
   logic [2:0]    wr_ofs = '0;
   logic [31:0]   wr_data = '0;
   bit            rd_cap = 1'b0;
   logic [2:0]    rd_ofs = '0;
   bit            chk_en = 1'b0;

   function automatic logic [31:0] model_read(input logic [2:0] ofs);
      case (ofs)
         3'd0:    return {24'h0, m_pins[1]};
         3'd1:    return {24'h0, m_out};
         3'd2:    return {24'h0, m_dir};
         3'd3:    return {24'h0, m_rise};
         3'd4:    return {24'h0, m_fall};
         3'd5:    return {24'h0, m_status};
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk) begin : ref_model
      logic [GW-1:0] rise_v, fall_v, clr_v;
      if (rst) begin
         m_pins   = '{8'h00, 8'h00, 8'h00};
         m_out    = '0;
         m_dir    = '0;
         m_rise   = '0;
         m_fall   = '0;
         m_status = '0;
         m_irq    = 1'b0;
         wr_pend  = 1'b0;
         rd_cap   = 1'b0;
      end else begin
         if (rd_cap) begin
            exp_q.push_back({(rd_ofs >= 3'd6), model_read(rd_ofs)});
            rd_cap = 1'b0;
         end
         rise_v = m_pins[1] & ~m_pins[2];
         fall_v = ~m_pins[1] & m_pins[2];
         clr_v  = (wr_pend && wr_ofs == 3'd5) ? wr_data[GW-1:0] : '0;
         m_irq  = (m_status != '0);
         m_status = (m_status & ~clr_v) | (rise_v & m_rise) | (fall_v & m_fall);
         if (wr_pend) begin
            case (wr_ofs)
               3'd1:    m_out  = wr_data[GW-1:0];
               3'd2:    m_dir  = wr_data[GW-1:0];
               3'd3:    m_rise = wr_data[GW-1:0];
               3'd4:    m_fall = wr_data[GW-1:0];
               default: ;
            endcase
            wr_pend = 1'b0;
         end
         m_pins.push_front(gpio_i);
         void'(m_pins.pop_back());
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check_eq("irq", 32'(irq), 32'(m_irq));
         check_eq("gpio_o", 32'(gpio_o), 32'(m_out));
         check_eq("gpio_oe", 32'(gpio_oe), 32'(m_dir));
      end
   end

   // ---------------- driver tasks (entered #1 after a rising edge) ----------------
   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      paddr = addr; pwrite = 1'b1; pwdata = data; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      check_eq("wr_pready_access", 32'(pready), 32'd1);
      check_eq("wr_pslverror", 32'(pslverror), 32'(addr[4:2] >= 3'd6));
      penable = 1'b1;
      wr_pend = 1'b1; wr_ofs = addr[4:2]; wr_data = data;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      check_eq("wr_pready_idle", 32'(pready), 32'd0);
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
      logic [32:0] exp_v;
      paddr = addr; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
      rd_cap = 1'b1; rd_ofs = addr[4:2];
      @(posedge clk); #1;
      check_eq("rd_pready_access", 32'(pready), 32'd1);
      penable = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      data = prdata;
      err  = pslverror;
      check_eq("rd_pready_idle", 32'(pready), 32'd0);
      check_eq("rd_exp_avail", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         check_eq("rd_prdata", data, exp_v[31:0]);
         check_eq("rd_pslverror", 32'(err), 32'(exp_v[32]));
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] d;
      logic        e;
      int          n;
      logic [2:0]  ofs;
      logic [31:0] a;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state
      check_eq("rst_state", 32'(dbg_state), 32'd0);
      check_eq("rst_pready", 32'(pready), 32'd0);
      for (int i = 0; i < 6; i++) begin
         apb_read(32'(i * 4), d, e);
         check_eq("rst_read", d, 32'h0);
         check_eq("rst_err", 32'(e), 32'd0);
      end

      // Output path
      apb_write(32'h04, 32'hA5);
      apb_write(32'h08, 32'h0F);
      check_eq("out_gpio_o", 32'(gpio_o), 32'hA5);
      check_eq("out_gpio_oe", 32'(gpio_oe), 32'h0F);
      apb_read(32'h08, d, e);
      check_eq("out_dir_read", d, 32'h0000000F);

      // Rising-edge interrupt: irq four cycles after the pin edge
      apb_write(32'h0C, 32'h01);
      gpio_i[0] = 1'b1;
      n = 0;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (irq && n == 0) n = c;
      end
      check_eq("rise_irq_latency", 32'(n), 32'd4);
      apb_read(32'h00, d, e);
      check_eq("rise_in", d, 32'h01);
      apb_read(32'h14, d, e);
      check_eq("rise_status", d, 32'h01);
      apb_write(32'h14, 32'h01);
      check_eq("clr_irq_hold", 32'(irq), 32'd1);
      idle(1);
      check_eq("clr_irq_low", 32'(irq), 32'd0);

      // Edge arriving on the same edge as a W1C of that bit
      apb_write(32'h0C, 32'h02);
      apb_write(32'h10, 32'h02);
      gpio_i[1] = 1'b1;
      idle(5);
      apb_read(32'h14, d, e);
      check_eq("coll_pre_status", d, 32'h02);
      gpio_i[1] = 1'b0;
      idle(1);
      apb_write(32'h14, 32'h02);
      check_eq("coll_irq", 32'(irq), 32'd1);
      idle(1);
      check_eq("coll_irq_next", 32'(irq), 32'd1);
      apb_read(32'h14, d, e);
      check_eq("coll_status", d, 32'h02);
      apb_write(32'h14, 32'h02);
      idle(1);
      check_eq("coll_irq_clear", 32'(irq), 32'd0);

      // Unmapped offsets, width masking and address aliasing
      apb_read(32'h18, d, e);
      check_eq("err_prdata", d, 32'h0);
      check_eq("err_flag", 32'(e), 32'd1);
      apb_write(32'h1C, 32'h12345678);
      apb_write(32'h00, 32'hFFFFFFFF);
      apb_write(32'h04, 32'hFFFFFFFF);
      apb_read(32'h04, d, e);
      check_eq("width_out", d, 32'h000000FF);
      apb_read(32'hABCD_0027, d, e);
      check_eq("alias_out", d, 32'h000000FF);
      check_eq("alias_err", 32'(e), 32'd0);

      // Protocol violation and dropped access: no commit
      paddr = 32'h04; pwrite = 1'b1; pwdata = 32'h0; psel = 1'b1; penable = 1'b1;
      @(posedge clk); #1;
      check_eq("viol_pready", 32'(pready), 32'd0);
      check_eq("viol_state", 32'(dbg_state), 32'd0);
      psel = 1'b0; penable = 1'b0; pwdata = 32'h12;
      psel = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b1;
      @(posedge clk); #1;
      penable = 1'b0; pwrite = 1'b0;
      check_eq("drop_gpio_o", 32'(gpio_o), 32'hFF);
      check_eq("drop_state", 32'(dbg_state), 32'd0);

      // Reset during ACCESS aborts the write
      paddr = 32'h04; pwrite = 1'b1; pwdata = 32'h55; psel = 1'b1; penable = 1'b0;
      @(posedge clk); #1;
      penable = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check_eq("abort_gpio_o", 32'(gpio_o), 32'h0);
      apb_read(32'h04, d, e);
      check_eq("abort_out", d, 32'h0);

      // Randomized traffic against the model
      for (int it = 0; it < 300; it++) begin
         ofs = 3'($urandom_range(0, 7));
         a = ($urandom & 32'hFFFF_FFE0) | (32'(ofs) << 2) | 32'($urandom_range(0, 3));
         case ($urandom_range(0, 4))
            0: begin gpio_i = 8'($urandom); idle(1); end
            1: apb_write(a, $urandom);
            2: apb_read(a, d, e);
            3: idle($urandom_range(1, 4));
            default: begin
               gpio_i[$urandom_range(0, GW - 1)] ^= 1'b1;
               apb_write(a, $urandom);
            end
         endcase
      end
      idle(6);
      for (int i = 0; i < 8; i++) begin
         apb_read(32'(i * 4), d, e);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
